// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage arithmetic for the five-stage MIPS pipeline.
// Decodes ALUOp/funct into a 4-bit ALU operation and runs a 32-bit ALU with
// a zero flag. It also computes PC+4 and keeps a one-deep registered copy of
// the ALU result and zero flag for the EX/MEM boundary.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset (clears the registered copy)
//   aluop      ALUOp from the control unit
//   func       instruction funct field [5:0]
//   in1, in2   ALU operands A and B
//   pc_in      current PC
//   aluctrl    decoded ALU operation (combinational)
//   alu_out    ALU result (combinational)
//   zero       alu_out == 0 (combinational)
//   pc_plus4   pc_in + 4 (combinational)
//   alu_out_q  alu_out registered on the clock edge
//   zero_q     zero registered on the clock edge

module alu_exec_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  aluop,
    input  logic [5:0]  func,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic [31:0] pc_in,
    output logic [3:0]  aluctrl,
    output logic [31:0] alu_out,
    output logic        zero,
    output logic [31:0] pc_plus4,
    output logic [31:0] alu_out_q,
    output logic        zero_q
);

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;

    // ALUOp encodings
    localparam logic [1:0] AOP_LS  = 2'b00;
    localparam logic [1:0] AOP_BR  = 2'b01;
    localparam logic [1:0] AOP_R   = 2'b10;
    localparam logic [1:0] AOP_IMM = 2'b11;

    // R-type funct codes
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;
    localparam logic [5:0] FN_NOR = 6'h27;

    // ALU operation codes
    localparam logic [CW-1:0] OP_AND = 4'b0000;
    localparam logic [CW-1:0] OP_OR  = 4'b0001;
    localparam logic [CW-1:0] OP_ADD = 4'b0010;
    localparam logic [CW-1:0] OP_SUB = 4'b0110;
    localparam logic [CW-1:0] OP_SLT = 4'b0111;
    localparam logic [CW-1:0] OP_NOR = 4'b1100;
    localparam logic [CW-1:0] OP_INV = 4'b1111;

    logic [CW-1:0] w_ctrl;
    logic [DW-1:0] w_result;
    logic          w_zero;
    logic [DW-1:0] r_alu_out;
    logic          r_zero;

    // ALU-control decode
    always_comb begin
        w_ctrl = OP_INV;
        unique case (aluop)
            AOP_LS:  w_ctrl = OP_ADD;
            AOP_BR:  w_ctrl = OP_SUB;
            AOP_IMM: w_ctrl = OP_ADD;
            AOP_R: begin
                case (func)
                    FN_ADD:  w_ctrl = OP_ADD;
                    FN_SUB:  w_ctrl = OP_SUB;
                    FN_AND:  w_ctrl = OP_AND;
                    FN_OR:   w_ctrl = OP_OR;
                    FN_SLT:  w_ctrl = OP_SLT;
                    FN_NOR:  w_ctrl = OP_NOR;
                    default: w_ctrl = OP_INV;
                endcase
            end
            default: w_ctrl = OP_INV;
        endcase
    end

    // 32-bit ALU; unknown codes yield zero so the zero flag stays meaningful
    always_comb begin
        w_result = '0;
        case (w_ctrl)
            OP_AND:  w_result = in1 & in2;
            OP_OR:   w_result = in1 | in2;
            OP_ADD:  w_result = DW'(in1 + in2);
            OP_SUB:  w_result = DW'(in1 - in2);
            OP_SLT:  w_result = ($signed(in1) < $signed(in2)) ? DW'(1) : DW'(0);
            OP_NOR:  w_result = ~(in1 | in2);
            default: w_result = '0;
        endcase
    end

    assign w_zero   = (w_result == '0);
    assign aluctrl  = w_ctrl;
    assign alu_out  = w_result;
    assign zero     = w_zero;
    assign pc_plus4 = DW'(pc_in + DW'(4));

    // EX/MEM copy: loads every edge, reset clears both (zero_q reads 0, not 1)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_out <= '0;
            r_zero    <= 1'b0;
        end else begin
            r_alu_out <= w_result;
            r_zero    <= w_zero;
        end
    end

    assign alu_out_q = r_alu_out;
    assign zero_q    = r_zero;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases plus randomized
// traffic compared with a behavioural reference model.
module tb_alu_exec_unit;

    logic        clk;
    logic        rst;
    logic [1:0]  aluop;
    logic [5:0]  func;
    logic [31:0] in1, in2, pc_in;
    logic [3:0]  aluctrl;
    logic [31:0] alu_out, pc_plus4, alu_out_q;
    logic        zero, zero_q;

    int errors = 0;
    int checks = 0;

    alu_exec_unit dut (
        .clk       (clk),
        .rst       (rst),
        .aluop     (aluop),
        .func      (func),
        .in1       (in1),
        .in2       (in2),
        .pc_in     (pc_in),
        .aluctrl   (aluctrl),
        .alu_out   (alu_out),
        .zero      (zero),
        .pc_plus4  (pc_plus4),
        .alu_out_q (alu_out_q),
        .zero_q    (zero_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: operation code from the decode table
    function automatic logic [3:0] ref_ctrl(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'd0 || op == 2'd3) return 4'b0010;
        if (op == 2'd1) return 4'b0110;
        case (f)
            6'h20: return 4'b0010;
            6'h22: return 4'b0110;
            6'h24: return 4'b0000;
            6'h25: return 4'b0001;
            6'h2A: return 4'b0111;
            6'h27: return 4'b1100;
            default: return 4'b1111;
        endcase
    endfunction

    // Reference: result computed with wide integer arithmetic then truncated
    function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        longint la, lb;
        int     sa, sb;
        la = longint'({32'd0, a});
        lb = longint'({32'd0, b});
        sa = a;
        sb = b;
        case (c)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return 32'((la + lb) % 64'h1_0000_0000);
            4'b0110: return 32'((la - lb + 64'h1_0000_0000) % 64'h1_0000_0000);
            4'b0111: return (sa < sb) ? 32'd1 : 32'd0;
            4'b1100: return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, check combinational outputs, then the
    // registered copy one edge later.
    task automatic step(input logic r, input logic [1:0] op, input logic [5:0] f,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc);
        logic [3:0]  ec;
        logic [31:0] er;
        rst = r; aluop = op; func = f; in1 = a; in2 = b; pc_in = pc;
        ec = ref_ctrl(op, f);
        er = ref_alu(ec, a, b);
        #1;
        chk("aluctrl",  32'(aluctrl), 32'(ec));
        chk("alu_out",  alu_out, er);
        chk("zero",     32'(zero), (er == 32'd0) ? 32'd1 : 32'd0);
        chk("pc_plus4", pc_plus4, 32'((longint'({32'd0, pc}) + 4) % 64'h1_0000_0000));
        @(posedge clk);
        #1;
        chk("alu_out_q", alu_out_q, r ? 32'd0 : er);
        chk("zero_q",    32'(zero_q), r ? 32'd0 : ((er == 32'd0) ? 32'd1 : 32'd0));
    endtask

    initial begin
        logic [5:0] fset [6];
        fset = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27};
        rst = 1'b1; aluop = 2'd0; func = 6'd0; in1 = 32'd0; in2 = 32'd0; pc_in = 32'd0;

        // Reset held two edges with nonzero operands
        step(1'b1, 2'b00, 6'h00, 32'd3, 32'd4, 32'd0);
        step(1'b1, 2'b10, 6'h20, 32'h1234, 32'h1, 32'h0040_001C);
        // Direct constants for the reset state, independent of the model
        chk("rst_q_const", alu_out_q, 32'd0);
        chk("rst_zq_const", 32'(zero_q), 32'd0);

        // First load after reset deasserts: 3+4
        step(1'b0, 2'b00, 6'h00, 32'd3, 32'd4, 32'hFFFF_FFFC);
        chk("add_const", alu_out_q, 32'd7);
        chk("pc_wrap_const", pc_plus4, 32'd0);

        // Decode sweep
        for (int i = 0; i < 6; i++)
            step(1'b0, 2'b10, fset[i], 32'h0000_0010, 32'h0000_0003, 32'd0);
        step(1'b0, 2'b01, 6'h3F, 32'd10, 32'd4, 32'd0);
        step(1'b0, 2'b11, 6'h22, 32'd10, 32'd4, 32'd0);
        step(1'b0, 2'b10, 6'h3F, 32'hDEAD_BEEF, 32'd1, 32'd0);
        chk("inv_ctrl_const", 32'(aluctrl), 32'hF);
        chk("inv_zero_const", 32'(zero), 32'd1);

        // Arithmetic wrap
        step(1'b0, 2'b10, 6'h20, 32'hFFFF_FFFF, 32'd1, 32'h0040_001C);
        chk("pc_const", pc_plus4, 32'h0040_0020);
        step(1'b0, 2'b01, 6'h00, 32'd5, 32'd7, 32'd0);
        chk("sub_const", alu_out, 32'hFFFF_FFFE);
        step(1'b0, 2'b01, 6'h00, 32'd9, 32'd9, 32'd0);

        // Logic patterns
        step(1'b0, 2'b10, 6'h24, 32'hF0F0_1234, 32'h0FF0_FF00, 32'd0);
        chk("and_const", alu_out, 32'h00F0_1200);
        step(1'b0, 2'b10, 6'h25, 32'hF0F0_1234, 32'h0FF0_FF00, 32'd0);
        chk("or_const", alu_out, 32'hFFF0_FF34);
        step(1'b0, 2'b10, 6'h27, 32'hF0F0_1234, 32'h0FF0_FF00, 32'd0);
        chk("nor_const", alu_out, 32'h000F_00CB);

        // Signed slt
        step(1'b0, 2'b10, 6'h2A, 32'hFFFF_FFFF, 32'd1, 32'd0);
        chk("slt_neg_const", alu_out, 32'd1);
        step(1'b0, 2'b10, 6'h2A, 32'd1, 32'hFFFF_FFFF, 32'd0);
        step(1'b0, 2'b10, 6'h2A, 32'h8000_0000, 32'h8000_0000, 32'd0);

        // Mid-stream reset clears on that edge, then reload
        step(1'b1, 2'b00, 6'h00, 32'd100, 32'd200, 32'd8);
        step(1'b0, 2'b00, 6'h00, 32'd100, 32'd200, 32'd8);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            logic [5:0]  f;
            logic [31:0] a, b;
            f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fset[$urandom_range(0, 5)];
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? a : 32'($urandom);
            step(($urandom_range(0, 9) == 0), 2'($urandom), f, a, b, 32'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
